// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package fetch_stage_pkg;

  // IF/ID field widths
  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;
  localparam int OPC_W   = 5;

  // Bubble word (opcode 00001) and the opcode that stops fetching
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 16'h0800;
  localparam logic [OPC_W-1:0]   HALT_OPC_DEF  = 5'b00000;

  // Fetch controller states
  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_SQUASH = 2'b01,
    ST_HALTED = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder: 4-bit groups with lookahead across groups.
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] sum
);

  logic [14:0] g_s;
  logic [15:0] p_s;
  logic [2:0]  gg_s;
  logic [2:0]  pg_s;
  logic [3:0]  cg_s;
  logic [15:0] c_s;

  assign g_s = a[14:0] & b[14:0];
  assign p_s = a ^ b;

  // Group generate / propagate for one 4-bit slice
  function automatic logic [1:0] group_gp(input logic [3:0] g, input logic [3:0] p);
    group_gp = {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p};
  endfunction

  // Internal carries c1..c3 of a 4-bit slice from its carry-in
  function automatic logic [2:0] carries3(input logic [2:0] g, input logic [2:0] p, input logic cin);
    carries3[0] = g[0] | (p[0] & cin);
    carries3[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    carries3[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  endfunction

  // Group lookahead, then per-bit carries and the sum
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      {gg_s[k], pg_s[k]} = group_gp(g_s[4*k +: 4], p_s[4*k +: 4]);
    end
    cg_s[0] = ci;
    cg_s[1] = gg_s[0] | (pg_s[0] & ci);
    cg_s[2] = gg_s[1] | (pg_s[1] & gg_s[0]) | (pg_s[1] & pg_s[0] & ci);
    cg_s[3] = gg_s[2] | (pg_s[2] & gg_s[1]) | (pg_s[2] & pg_s[1] & gg_s[0])
            | (pg_s[2] & pg_s[1] & pg_s[0] & ci);
    for (int k = 0; k < 4; k++) begin
      c_s[4*k]         = cg_s[k];
      c_s[4*k+1 +: 3]  = carries3(g_s[4*k +: 3], p_s[4*k +: 3], cg_s[k]);
    end
    sum = p_s ^ c_s;
  end

endmodule

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: loads a fetched word, inserts a bubble, or holds.
module fetch_stage_ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               bubble_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [PC_W-1:0]    pc_plus_two_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [PC_W-1:0]    pc_plus_two_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pcp2_q;
  logic               valid_q;

  // Load has priority over bubble; a bubble keeps the previous pc fields
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 16'h0000;
      pcp2_q  <= 16'h0000;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      pcp2_q  <= pc_plus_two_i;
      valid_q <= 1'b1;
    end else if (bubble_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_q;
      valid_q <= valid_q;
    end
  end

  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign pc_plus_two_o = pcp2_q;
  assign valid_o       = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, variable-latency imem handshake,
// redirect/stall handling and the IF/ID register feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter logic [OPC_W-1:0]   HALT_OPC  = HALT_OPC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_flush,
  input  logic [PC_W-1:0]    next_pc,
  input  logic               pcWriteEn,
  input  logic               IFIDWriteEn,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus_two,
  output logic               ifid_valid,
  output logic               halted
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            halted_q, halted_d;
  logic [PC_W-1:0] pc_inc_s;
  logic            ifid_load_s;
  logic            ifid_bubble_s;

  cla_16bit u_pc_inc (
    .a   (pc_q),
    .b   (16'h0002),
    .ci  (1'b0),
    .sum (pc_inc_s)
  );

  // Next-state, PC update and IF/ID control for each fetch state
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    halted_d      = halted_q;
    ifid_load_s   = 1'b0;
    ifid_bubble_s = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (if_flush && imem_ready) begin
          pc_d          = next_pc;
          ifid_bubble_s = 1'b1;
        end else if (if_flush) begin
          // Memory still busy at the old address: remember the target
          redirect_pc_d = next_pc;
          ifid_bubble_s = 1'b1;
          state_d       = ST_SQUASH;
        end else if (imem_ready && pcWriteEn && IFIDWriteEn) begin
          ifid_load_s = 1'b1;
          pc_d        = pc_inc_s;
          if (imem_data[15:11] == HALT_OPC) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          // Stalled or waiting: PC held, so a dropped word is refetched
          ifid_bubble_s = IFIDWriteEn;
        end
      end
      ST_SQUASH: begin
        ifid_bubble_s = IFIDWriteEn;
        if (imem_ready) begin
          pc_d    = redirect_pc_q;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_SQUASH;
        end
      end
      ST_HALTED: begin
        ifid_bubble_s = IFIDWriteEn;
      end
      default: begin
        state_d       = ST_FETCH;
        ifid_bubble_s = IFIDWriteEn;
      end
    endcase
  end

  // Fetch controller registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      redirect_pc_q <= 16'h0000;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      halted_q      <= halted_d;
    end
  end

  fetch_stage_ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk           (clk),
    .rst           (rst),
    .load_i        (ifid_load_s),
    .bubble_i      (ifid_bubble_s),
    .instr_i       (imem_data),
    .pc_i          (pc_q),
    .pc_plus_two_i (pc_inc_s),
    .instr_o       (instr),
    .pc_o          (pc),
    .pc_plus_two_o (pc_plus_two),
    .valid_o       (ifid_valid)
  );

  assign imem_req  = !rst && ((state_q == ST_FETCH) || (state_q == ST_SQUASH));
  assign imem_addr = pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with hand-computed expected values.
// Memory model: word at address A is 16'h4000 + A/2 + 1, except halt_addr returns 16'h0000.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_flush;
  logic [15:0] next_pc;
  logic        pcWriteEn;
  logic        IFIDWriteEn;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] instr;
  logic [15:0] pc;
  logic [15:0] pc_plus_two;
  logic        ifid_valid;
  logic        halted;

  logic [15:0] halt_addr = 16'h0086;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_data = (imem_addr == halt_addr) ? 16'h0000
                   : 16'h4000 + {1'b0, imem_addr[15:1]} + 16'h0001;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .if_flush    (if_flush),
    .next_pc     (next_pc),
    .pcWriteEn   (pcWriteEn),
    .IFIDWriteEn (IFIDWriteEn),
    .imem_ready  (imem_ready),
    .imem_data   (imem_data),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .instr       (instr),
    .pc          (pc),
    .pc_plus_two (pc_plus_two),
    .ifid_valid  (ifid_valid),
    .halted      (halted)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] e_instr, input logic [15:0] e_pc,
                            input logic [15:0] e_pcp2, input logic e_valid);
    check_eq({tag, ".instr"}, instr, e_instr);
    check_eq({tag, ".pc"}, pc, e_pc);
    check_eq({tag, ".pcp2"}, pc_plus_two, e_pcp2);
    check_eq({tag, ".valid"}, {15'd0, ifid_valid}, {15'd0, e_valid});
  endtask

  initial begin
    rst = 1'b1; if_flush = 1'b0; next_pc = 16'h0000;
    pcWriteEn = 1'b1; IFIDWriteEn = 1'b1; imem_ready = 1'b0;
    tick(); tick();
    // Reset state
    check_eq("rst.req", {15'd0, imem_req}, 16'h0000);
    check_eq("rst.halted", {15'd0, halted}, 16'h0000);
    check_ifid("rst", 16'h0800, 16'h0000, 16'h0000, 1'b0);

    // Sequential fetch
    rst = 1'b0; imem_ready = 1'b1; #1;
    check_eq("seq.req", {15'd0, imem_req}, 16'h0001);
    check_eq("seq.addr0", imem_addr, 16'h0000);
    tick();
    check_ifid("seq0", 16'h4001, 16'h0000, 16'h0002, 1'b1);
    check_eq("seq.addr1", imem_addr, 16'h0002);
    tick();
    check_ifid("seq1", 16'h4002, 16'h0002, 16'h0004, 1'b1);
    check_eq("seq.addr2", imem_addr, 16'h0004);

    // Multi-cycle memory: three wait cycles then the word
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("wait.addr", imem_addr, 16'h0004);
      check_ifid("wait", 16'h0800, 16'h0002, 16'h0004, 1'b0);
    end
    imem_ready = 1'b1;
    tick();
    check_ifid("wait.word", 16'h4003, 16'h0004, 16'h0006, 1'b1);
    check_eq("wait.addr_next", imem_addr, 16'h0006);

    // Redirect with data ready
    if_flush = 1'b1; next_pc = 16'h0040;
    tick();
    check_ifid("rdy_flush", 16'h0800, 16'h0004, 16'h0006, 1'b0);
    check_eq("rdy_flush.addr", imem_addr, 16'h0040);
    if_flush = 1'b0;
    tick();
    check_ifid("rdy_flush.tgt", 16'h4021, 16'h0040, 16'h0042, 1'b1);
    check_eq("rdy_flush.addr2", imem_addr, 16'h0042);

    // Redirect with request pending; a second flush while squashing is ignored
    imem_ready = 1'b0; if_flush = 1'b1; next_pc = 16'h0080;
    tick();
    check_eq("sq.addr_hold", imem_addr, 16'h0042);
    check_ifid("sq0", 16'h0800, 16'h0040, 16'h0042, 1'b0);
    next_pc = 16'h1234;
    tick();
    check_eq("sq.req", {15'd0, imem_req}, 16'h0001);
    check_eq("sq.addr_hold2", imem_addr, 16'h0042);
    if_flush = 1'b0; imem_ready = 1'b1;
    tick();
    check_ifid("sq.discard", 16'h0800, 16'h0040, 16'h0042, 1'b0);
    check_eq("sq.addr_tgt", imem_addr, 16'h0080);
    tick();
    check_ifid("sq.tgt", 16'h4041, 16'h0080, 16'h0082, 1'b1);
    check_eq("sq.addr_next", imem_addr, 16'h0082);

    // Full stall for two cycles with data ready
    pcWriteEn = 1'b0; IFIDWriteEn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_ifid("stall", 16'h4041, 16'h0080, 16'h0082, 1'b1);
      check_eq("stall.addr", imem_addr, 16'h0082);
    end
    pcWriteEn = 1'b1; IFIDWriteEn = 1'b1;
    tick();
    check_ifid("stall.resume", 16'h4042, 16'h0082, 16'h0084, 1'b1);
    // PC stall only: word dropped, bubble inserted, same address refetched
    pcWriteEn = 1'b0;
    tick();
    check_ifid("pcstall", 16'h0800, 16'h0082, 16'h0084, 1'b0);
    check_eq("pcstall.addr", imem_addr, 16'h0084);
    pcWriteEn = 1'b1;
    tick();
    check_ifid("pcstall.refetch", 16'h4043, 16'h0084, 16'h0086, 1'b1);

    // Halt word at 0x0086
    tick();
    check_ifid("halt.word", 16'h0000, 16'h0086, 16'h0088, 1'b1);
    check_eq("halt.flag", {15'd0, halted}, 16'h0001);
    check_eq("halt.req", {15'd0, imem_req}, 16'h0000);
    tick();
    check_ifid("halt.bubble", 16'h0800, 16'h0086, 16'h0088, 1'b0);
    check_eq("halt.pc_frozen", imem_addr, 16'h0088);
    if_flush = 1'b1; next_pc = 16'h0010;
    tick();
    if_flush = 1'b0;
    check_eq("halt.stays", {15'd0, halted}, 16'h0001);
    check_eq("halt.addr_frozen", imem_addr, 16'h0088);

    // Reset restarts fetching at 0
    rst = 1'b1;
    tick();
    check_eq("rst2.halted", {15'd0, halted}, 16'h0000);
    check_ifid("rst2", 16'h0800, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b0; #1;
    check_eq("rst2.req", {15'd0, imem_req}, 16'h0001);
    check_eq("rst2.addr", imem_addr, 16'h0000);

    // Wrap at 0xFFFE
    if_flush = 1'b1; next_pc = 16'hFFFE;
    tick();
    check_eq("wrap.addr", imem_addr, 16'hFFFE);
    if_flush = 1'b0;
    tick();
    check_ifid("wrap", 16'hC000, 16'hFFFE, 16'h0000, 1'b1);
    check_eq("wrap.addr_next", imem_addr, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
